// File: rtl/line_fetcher_pkg.sv
// Shared types and sizing helpers for the framebuffer line fetcher.
package line_fetcher_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned FifoDepth = 16;
  localparam int unsigned LevelW    = level_width(FifoDepth);

endpackage

// File: rtl/line_fifo.sv
// First-word-fall-through line FIFO; the head word comes straight from registered storage.
module line_fifo
  import line_fetcher_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned LW   = level_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/line_fetcher.sv
// Per-line Wishbone read burst into a line FIFO feeding the video shifter.
// Optional LINE_FETCHER_DOUBLESCAN_EN fetches every source line twice.
module line_fetcher
  import line_fetcher_pkg::*;
#(
  parameter int unsigned AW    = 23,
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 8,
  parameter int unsigned DEPTH = FifoDepth
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          hsync_i,
  input  logic          vsync_i,
  input  logic          den_i,
  input  logic [AW-1:0] fb_adr_i,
  input  logic [AW-1:0] stride_i,
  input  logic [CW-1:0] words_i,
  output logic [AW-1:0] adr_o,
  output logic          cyc_o,
  output logic          stb_o,
  input  logic          ack_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] pix_o,
  output logic          valid_o,
  input  logic          rdy_i,
  output logic          underrun_o
);

  localparam int unsigned LW = level_width(DEPTH);

  state_e        state_q, state_d;
  logic          hsync_q;
  logic [AW-1:0] line_base_q, line_base_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          cyc_q, cyc_d;
  logic          underrun_q, underrun_d;
`ifdef LINE_FETCHER_DOUBLESCAN_EN
  logic          toggle_q, toggle_d;
`endif

  logic [LW-1:0] fifo_level;
  logic          fifo_full, fifo_empty, fifo_flush, fifo_push, fifo_pop;
  logic          trigger, ack_take;

  assign stb_o    = cyc_q & (fifo_level < LW'(DEPTH));
  assign ack_take = cyc_q & stb_o & ack_i;
  assign trigger  = hsync_i & ~hsync_q & den_i & (words_i != '0);
  // Acks arriving while VSYNC aborts the cycle are dropped.
  assign fifo_push = ack_take & ~vsync_i & ~fifo_full;
  assign fifo_pop  = rdy_i & ~fifo_empty;

  always_comb begin
    state_d     = state_q;
    line_base_d = line_base_q;
    adr_d       = adr_q;
    remaining_d = remaining_q;
    cyc_d       = cyc_q;
    fifo_flush  = 1'b0;
`ifdef LINE_FETCHER_DOUBLESCAN_EN
    toggle_d    = toggle_q;
`endif
    if (vsync_i) begin
      state_d     = StIdle;
      cyc_d       = 1'b0;
      fifo_flush  = 1'b1;
      line_base_d = fb_adr_i;
      adr_d       = fb_adr_i;
`ifdef LINE_FETCHER_DOUBLESCAN_EN
      toggle_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            adr_d       = line_base_q;
            remaining_d = words_i;
            cyc_d       = 1'b1;
            state_d     = StFetch;
          end
        end
        StFetch: begin
          if (ack_take) begin
            adr_d       = adr_q + AW'(1);
            remaining_d = remaining_q - CW'(1);
            if (remaining_q == CW'(1)) begin
              cyc_d   = 1'b0;
              state_d = StHold;
`ifdef LINE_FETCHER_DOUBLESCAN_EN
              // Advance only after the second pass over the same source line.
              if (toggle_q) line_base_d = line_base_q + stride_i;
              toggle_d = ~toggle_q;
`else
              line_base_d = line_base_q + stride_i;
`endif
            end
          end
        end
        StHold: begin
          if (!hsync_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (vsync_i) begin
      underrun_d = 1'b0;
    end else if (den_i && rdy_i && fifo_empty) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      hsync_q     <= 1'b0;
      line_base_q <= '0;
      adr_q       <= '0;
      remaining_q <= '0;
      cyc_q       <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef LINE_FETCHER_DOUBLESCAN_EN
      toggle_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hsync_q     <= hsync_i;
      line_base_q <= line_base_d;
      adr_q       <= adr_d;
      remaining_q <= remaining_d;
      cyc_q       <= cyc_d;
      underrun_q  <= underrun_d;
`ifdef LINE_FETCHER_DOUBLESCAN_EN
      toggle_q    <= toggle_d;
`endif
    end
  end

  line_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_line_fifo (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .push      (fifo_push),
    .push_data (dat_i),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (pix_o)
  );

  assign adr_o      = adr_q;
  assign cyc_o      = cyc_q;
  assign valid_o    = ~fifo_empty;
  assign underrun_o = underrun_q;

endmodule

// File: doc/line_fetcher.md
# line_fetcher

Parametrised framebuffer line fetcher for the CGIA video path. It sits between the CRTC timing signals and the video shifter. On each displayed line it runs a Wishbone-style master read burst of a programmable word count, starting at a per-line base address. Fetched words go into a line FIFO, and the base address advances by a programmable stride each line.

## Interface
- AW, 23, word-address width (adr_o covers byte address bits [AW:1])
- DW, 16, data word width
- CW, 8, width of the words-per-line count
- DEPTH, 16, FIFO depth in words (power of two, ≥2)
- clk_i  in  1  SYSCON clock; all logic on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- hsync_i  in  1  CRTC HSYNC, active high
- vsync_i  in  1  CRTC VSYNC, active high
- den_i  in  1  CRTC display enable
- fb_adr_i  in  AW  frame base address, loaded during VSYNC
- stride_i  in  AW  line pitch in words
- words_i  in  CW  words fetched per line
- adr_o  out  AW  master address
- cyc_o  out  1  master cycle in progress
- stb_o  out  1  master strobe
- ack_i  in  1  slave acknowledge
- dat_i  in  DW  read data
- pix_o  out  DW  FIFO head word to the shifter
- valid_o  out  1  FIFO non-empty
- rdy_i  in  1  shifter pops the head when valid_o & rdy_i
- underrun_o  out  1  sticky underrun flag

## Operation
- States: IDLE, FETCH, HOLD.
- Registers:
  - hsync_q: delayed hsync_i
  - line_base: AW bits
  - remaining: CW bits
- Trigger: hsync_i & ~hsync_q & den_i & ~vsync_i & (words_i ≠ 0), in IDLE.
- IDLE → FETCH on trigger:
  - adr_o ← line_base
  - remaining ← words_i
  - cyc_o ← 1
- FETCH:
  - stb_o = cyc_o & (FIFO level < DEPTH). This is combinational, so a full FIFO withholds the strobe while cyc_o stays high.
  - On each ack_i: push dat_i, adr_o ← adr_o+1, remaining ← remaining−1.
  - On the ack with remaining==1: cyc_o ← 0, line_base ← line_base+stride_i (modulo 2^AW), go to HOLD.
- HOLD → IDLE when hsync_i is low. This prevents a re-trigger within one sync pulse.
- words_i==0 at trigger: no bus cycle, line_base unchanged, stay IDLE.
- vsync_i high overrides any state:
  - next edge: state IDLE, cyc_o=0, FIFO flushed, line_base ← fb_adr_i, adr_o ← fb_adr_i
  - An aborted bus cycle is legal; the ack_i of a dropped cycle is ignored.
- underrun_o sets when den_i & rdy_i & ~valid_o. It clears only while vsync_i is high.
- Pop and push in the same cycle are allowed; the level is unchanged.
- Reset values: state IDLE, cyc_o 0, stb_o 0, adr_o 0, line_base 0, remaining 0, FIFO empty, valid_o 0, underrun_o 0, pix_o 0.

## Timing
- Trigger sampled at edge N → cyc_o=stb_o=1 and adr_o=line_base visible after N+1.
- Zero-wait slave (ack_i every cycle): a W-word line completes in W cycles; cyc_o low after edge N+W+1.
- ack_i→data: the pushed word is visible on pix_o/valid_o one cycle after the push edge if the FIFO was empty. FIFO is first-word-fall-through from its registered storage.
- Stride is sampled on the final ack edge; fb_adr_i is sampled on every edge while vsync_i is high.
- Reset assertion at any time forces reset values asynchronously. Deassertion is synchronised by the SYSCON block upstream.

## Configuration
- LINE_FETCHER_DOUBLESCAN_EN defined:
  - A toggle bit, cleared by vsync_i/reset, flips on each completed line.
  - line_base advances by stride only when the toggle was 1, so each source line is fetched twice.
- Undefined: line_base advances on every completed line; no toggle register exists.

## Structure
- Package line_fetcher_pkg: state enum (IDLE, FETCH, HOLD), a localparam for FIFO level width = $clog2(DEPTH)+1.
- Sub-module line_fifo: synchronous first-word-fall-through FIFO with parameters DW and DEPTH, ports push, pop, flush, level, full/empty. Same clock and reset as the parent.
- The FSM, address counters and underrun logic stay in line_fetcher.

## Test plan
- Basic line: fb_adr_i=0x1000 during VSYNC, words_i=4, ack_i tied high, hsync rising edge with den_i → adr_o 0x1000..0x1003, exactly 4 acks taken, 4 words on pix_o in order, cyc_o low after.
- Stride: stride_i=0x50, three lines of 4 words → second line starts at 0x1050, third line at 0x10A0. With LINE_FETCHER_DOUBLESCAN_EN: starts are 0x1000, 0x1000, 0x1050.
- Backpressure: DEPTH=4, words_i=8, rdy_i=0 → stb_o drops after 4 acks with cyc_o high. Set rdy_i=1 → fetch resumes and all 8 words arrive in order.
- VSYNC abort: assert vsync_i mid-burst after 2 of 8 acks → next edge cyc_o=0, valid_o=0, adr_o=fb_adr_i. A stray ack_i is ignored.
- Underrun: den_i=1, rdy_i=1, FIFO empty → underrun_o=1, held until vsync_i high, then 0.
- Async reset: pull reset_ni low mid-FETCH between clock edges → cyc_o, stb_o, valid_o drop immediately and all outputs take reset values.
